// File: rtl/parallax_scroll_ctrl.sv
// Three-layer parallax scroll scheduler: shadowed config, one shared adder stepped once per frame.
// Optional PARALLAX_PAUSE_EN adds i_pause, which holds off frame sequencing while asserted.
module parallax_scroll_ctrl #(
  parameter int unsigned SPEED0_INIT = 4,
  parameter int unsigned SPEED1_INIT = 2,
  parameter int unsigned SPEED2_INIT = 1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_frame_start,
`ifdef PARALLAX_PAUSE_EN
  input  logic       i_pause,
`endif
  input  logic       i_cfg_valid,
  output logic       o_cfg_ready,
  input  logic [2:0] i_cfg_addr,
  input  logic [7:0] i_cfg_data,
  output logic [9:0] o_scroll_x0,
  output logic [9:0] o_scroll_x1,
  output logic [9:0] o_scroll_x2,
  output logic [2:0] o_layer_en,
  output logic [4:0] o_frame,
  output logic       o_update_done,
  output logic       o_overrun
);

  typedef enum logic [2:0] {StIdle, StCommit, StL0, StL1, StL2, StDone} state_t;

  localparam logic [2:0][3:0] SpeedInit = {4'(SPEED2_INIT), 4'(SPEED1_INIT), 4'(SPEED0_INIT)};

  state_t           r_state;
  logic [2:0][11:0] r_acc;
  logic [2:0][3:0]  r_spd;
  logic [2:0][3:0]  r_shd_spd;
  logic [2:0]       r_mask;
  logic [2:0]       r_shd_mask;
  logic [2:0]       r_dir;
  logic [2:0]       r_shd_dir;
  logic             r_zero_req;
  logic [4:0]       r_frame;
  logic             r_update_done;
  logic             r_overrun;

  logic        w_idle;
  logic        w_go;
  logic        w_cfg_we;
  logic [1:0]  w_lane;
  logic [11:0] w_acc_sel;
  logic [11:0] w_spd_sel;
  logic [11:0] w_sum;
  logic        w_unused_data;

  assign w_idle   = (r_state == StIdle);
  assign w_cfg_we = i_cfg_valid && w_idle;
`ifdef PARALLAX_PAUSE_EN
  assign w_go     = i_frame_start && w_idle && !i_pause;
`else
  assign w_go     = i_frame_start && w_idle;
`endif
  assign w_unused_data = ^i_cfg_data[7:4];

  // Lane select for the shared adder; only meaningful in the three layer states.
  always_comb begin
    w_lane = 2'd0;
    case (r_state)
      StL1:    w_lane = 2'd1;
      StL2:    w_lane = 2'd2;
      default: w_lane = 2'd0;
    endcase
  end

  assign w_acc_sel = r_acc[w_lane];
  assign w_spd_sel = {8'd0, r_spd[w_lane]};
  assign w_sum     = r_dir[w_lane] ? (w_acc_sel - w_spd_sel) : (w_acc_sel + w_spd_sel);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= StIdle;
      r_acc         <= '0;
      r_spd         <= SpeedInit;
      r_shd_spd     <= SpeedInit;
      r_mask        <= 3'b111;
      r_shd_mask    <= 3'b111;
      r_dir         <= 3'b000;
      r_shd_dir     <= 3'b000;
      r_zero_req    <= 1'b0;
      r_frame       <= '0;
      r_update_done <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_update_done <= 1'b0;
      if (w_cfg_we) begin
        case (i_cfg_addr)
          3'd0:    r_shd_spd[0] <= i_cfg_data[3:0];
          3'd1:    r_shd_spd[1] <= i_cfg_data[3:0];
          3'd2:    r_shd_spd[2] <= i_cfg_data[3:0];
          3'd3:    r_shd_mask   <= i_cfg_data[2:0];
          3'd4:    r_shd_dir    <= i_cfg_data[2:0];
          3'd5:    r_zero_req   <= 1'b1;
          default: ;
        endcase
      end
      if (i_frame_start && !w_idle) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        StIdle: begin
          if (w_go) r_state <= StCommit;
        end
        StCommit: begin
          r_spd   <= r_shd_spd;
          r_mask  <= r_shd_mask;
          r_dir   <= r_shd_dir;
          r_frame <= r_frame + 5'd1;
          if (r_zero_req) begin
            r_acc      <= '0;
            r_zero_req <= 1'b0;
          end
          r_state <= StL0;
        end
        StL0, StL1, StL2: begin
          if (r_mask[w_lane]) r_acc[w_lane] <= w_sum;
          if (r_state == StL0) begin
            r_state <= StL1;
          end else if (r_state == StL1) begin
            r_state <= StL2;
          end else begin
            r_state       <= StDone;
            r_update_done <= 1'b1;
          end
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_cfg_ready   = w_idle;
  assign o_scroll_x0   = r_acc[0][11:2];
  assign o_scroll_x1   = r_acc[1][11:2];
  assign o_scroll_x2   = r_acc[2][11:2];
  assign o_layer_en    = r_mask;
  assign o_frame       = r_frame;
  assign o_update_done = r_update_done;
  assign o_overrun     = r_overrun;

endmodule

// File: tb/tb_parallax_scroll_ctrl.sv
// Self-checking bench for parallax_scroll_ctrl: fixed vector table, corner sequences and
// randomized config/frame traffic checked against a per-frame arithmetic model.
module tb_parallax_scroll_ctrl;

  logic       clk = 1'b0;
  logic       i_reset;
  logic       i_frame_start;
`ifdef PARALLAX_PAUSE_EN
  logic       i_pause;
`endif
  logic       i_cfg_valid;
  logic       o_cfg_ready;
  logic [2:0] i_cfg_addr;
  logic [7:0] i_cfg_data;
  logic [9:0] o_scroll_x0, o_scroll_x1, o_scroll_x2;
  logic [2:0] o_layer_en;
  logic [4:0] o_frame;
  logic       o_update_done;
  logic       o_overrun;

  always #5 clk = ~clk;

  parallax_scroll_ctrl dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_frame_start (i_frame_start),
`ifdef PARALLAX_PAUSE_EN
    .i_pause       (i_pause),
`endif
    .i_cfg_valid   (i_cfg_valid),
    .o_cfg_ready   (o_cfg_ready),
    .i_cfg_addr    (i_cfg_addr),
    .i_cfg_data    (i_cfg_data),
    .o_scroll_x0   (o_scroll_x0),
    .o_scroll_x1   (o_scroll_x1),
    .o_scroll_x2   (o_scroll_x2),
    .o_layer_en    (o_layer_en),
    .o_frame       (o_frame),
    .o_update_done (o_update_done),
    .o_overrun     (o_overrun)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: accumulators in quarter pixels, updated once per frame.
  int m_acc[3], m_pre[3], m_spd[3], m_sspd[3];
  int m_mask, m_smask, m_dir, m_sdir, m_frame;
  bit m_zero;

  function automatic void model_reset();
    m_sspd[0] = 4; m_sspd[1] = 2; m_sspd[2] = 1;
    for (int k = 0; k < 3; k++) begin
      m_spd[k] = m_sspd[k];
      m_acc[k] = 0;
      m_pre[k] = 0;
    end
    m_mask = 7; m_smask = 7; m_dir = 0; m_sdir = 0; m_frame = 0; m_zero = 0;
  endfunction

  function automatic void model_write(input int a, input int d);
    if (a <= 2)      m_sspd[a] = d % 16;
    else if (a == 3) m_smask   = d % 8;
    else if (a == 4) m_sdir    = d % 8;
    else if (a == 5) m_zero    = 1;
  endfunction

  function automatic void model_frame();
    for (int k = 0; k < 3; k++) m_spd[k] = m_sspd[k];
    m_mask  = m_smask;
    m_dir   = m_sdir;
    m_frame = (m_frame + 1) % 32;
    if (m_zero) begin
      for (int k = 0; k < 3; k++) m_acc[k] = 0;
      m_zero = 0;
    end
    for (int k = 0; k < 3; k++) begin
      m_pre[k] = m_acc[k];
      if (((m_mask >> k) & 1) == 1) begin
        if (((m_dir >> k) & 1) == 1) m_acc[k] = (m_acc[k] - m_spd[k] + 4096) % 4096;
        else                         m_acc[k] = (m_acc[k] + m_spd[k]) % 4096;
      end
    end
  endfunction

  task automatic check_model(input string tag);
    check({tag, "_x0"}, o_scroll_x0, m_acc[0] / 4);
    check({tag, "_x1"}, o_scroll_x1, m_acc[1] / 4);
    check({tag, "_x2"}, o_scroll_x2, m_acc[2] / 4);
    check({tag, "_en"}, o_layer_en, m_mask);
    check({tag, "_frame"}, o_frame, m_frame);
  endtask

  task automatic cfg_write(input int a, input int d);
    @(negedge clk);
    i_cfg_valid = 1'b1;
    i_cfg_addr  = 3'(a);
    i_cfg_data  = 8'(d);
    check("cfg_ready_idle", o_cfg_ready, 1);
    @(posedge clk);
    @(negedge clk);
    i_cfg_valid = 1'b0;
    model_write(a, d);
  endtask

  // One full frame with per-edge latency checks; optional write on the frame_start edge.
  task automatic run_frame(input int gap, input bit wr, input int a, input int d);
    @(negedge clk);
    i_frame_start = 1'b1;
    if (wr) begin
      i_cfg_valid = 1'b1;
      i_cfg_addr  = 3'(a);
      i_cfg_data  = 8'(d);
      check("cfg_ready_at_start", o_cfg_ready, 1);
      model_write(a, d);
    end
    model_frame();
    @(posedge clk);
    @(negedge clk);
    i_frame_start = 1'b0;
    i_cfg_valid   = 1'b0;
    check("cfg_ready_commit", o_cfg_ready, 0);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("update_done", o_update_done, (k == 4));
      check("cfg_ready_seq", o_cfg_ready, (k == 5));
      case (k)
        1: begin
          check("lat_x0_pre", o_scroll_x0, m_pre[0] / 4);
          check("lat_x1_pre", o_scroll_x1, m_pre[1] / 4);
          check("lat_x2_pre", o_scroll_x2, m_pre[2] / 4);
          check("lat_frame", o_frame, m_frame);
          check("lat_en", o_layer_en, m_mask);
        end
        2: begin
          check("lat_x0_post", o_scroll_x0, m_acc[0] / 4);
          check("lat_x1_pre2", o_scroll_x1, m_pre[1] / 4);
        end
        3: begin
          check("lat_x1_post", o_scroll_x1, m_acc[1] / 4);
          check("lat_x2_pre3", o_scroll_x2, m_pre[2] / 4);
        end
        4: check("lat_x2_post", o_scroll_x2, m_acc[2] / 4);
        default: ;
      endcase
    end
    repeat (gap) @(negedge clk);
  endtask

  typedef struct {
    int addr; int data; int nfr; int gap;
    int x0; int x1; int x2; int en; int frame;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nud;
    tbl[0] = '{7, 8'h55, 4, 794, 4,    2, 1, 7, 4};
    tbl[1] = '{5, 0,     0, 0,   4,    2, 1, 7, 4};
    tbl[2] = '{4, 1,     0, 0,   4,    2, 1, 7, 4};
    tbl[3] = '{0, 8,     1, 3,   1022, 0, 0, 7, 5};
    tbl[4] = '{3, 2,     2, 3,   1022, 1, 0, 2, 7};
    tbl[5] = '{1, 0,     1, 3,   1022, 1, 0, 2, 8};
    tbl[6] = '{3, 7,     1, 3,   1020, 1, 0, 7, 9};
    tbl[7] = '{4, 0,     1, 3,   1022, 1, 0, 7, 10};
    tbl[8] = '{2, 15,    1, 3,   0,    1, 4, 7, 11};

    i_reset = 1'b1; i_frame_start = 1'b0; i_cfg_valid = 1'b0;
    i_cfg_addr = '0; i_cfg_data = '0;
`ifdef PARALLAX_PAUSE_EN
    i_pause = 1'b0;
`endif
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_x0", o_scroll_x0, 0);
    check("rst_x1", o_scroll_x1, 0);
    check("rst_x2", o_scroll_x2, 0);
    check("rst_frame", o_frame, 0);
    check("rst_en", o_layer_en, 7);
    check("rst_ready", o_cfg_ready, 1);
    check("rst_done", o_update_done, 0);
    check("rst_overrun", o_overrun, 0);
    i_reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      cfg_write(tbl[i].addr, tbl[i].data);
      for (int f = 0; f < tbl[i].nfr; f++) run_frame(tbl[i].gap, 1'b0, 0, 0);
      check("tbl_x0", o_scroll_x0, tbl[i].x0);
      check("tbl_x1", o_scroll_x1, tbl[i].x1);
      check("tbl_x2", o_scroll_x2, tbl[i].x2);
      check("tbl_en", o_layer_en, tbl[i].en);
      check("tbl_frame", o_frame, tbl[i].frame);
    end

`ifdef PARALLAX_PAUSE_EN
    i_pause = 1'b1;
    for (int f = 0; f < 3; f++) begin
      @(negedge clk);
      i_frame_start = 1'b1;
      @(negedge clk);
      i_frame_start = 1'b0;
      check("pause_ready", o_cfg_ready, 1);
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        check("pause_done", o_update_done, 0);
      end
    end
    cfg_write(5, 0);
    check_model("pause");
    check("pause_overrun", o_overrun, 0);
    i_pause = 1'b0;
`endif

    // Write held during L1 must stall until the first IDLE cycle.
    @(negedge clk);
    i_frame_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_frame_start = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    i_cfg_valid = 1'b1; i_cfg_addr = 3'd3; i_cfg_data = 8'h01;
    for (int k = 2; k <= 4; k++) begin
      check("stall_ready", o_cfg_ready, 0);
      @(posedge clk);
      @(negedge clk);
    end
    check("stall_ready_idle", o_cfg_ready, 1);
    @(posedge clk);
    @(negedge clk);
    i_cfg_valid = 1'b0;
    model_frame();
    check_model("stall_frame");
    model_write(3, 1);
    run_frame(2, 1'b0, 0, 0);
    check("stall_mask", o_layer_en, 1);

    // Second frame_start two edges after the first is ignored and flagged.
    check("ovr_pre", o_overrun, 0);
    nud = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      nud += int'(o_update_done);
      i_frame_start = (c == 0 || c == 2);
    end
    model_frame();
    check("ovr_done_count", nud, 1);
    check("ovr_set", o_overrun, 1);
    check_model("ovr");
    run_frame(2, 1'b0, 0, 0);
    check("ovr_sticky", o_overrun, 1);

    // Reset during L1 aborts the sequence immediately.
    @(negedge clk);
    i_frame_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_frame_start = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    i_reset = 1'b1;
    #1;
    check("mid_rst_x0", o_scroll_x0, 0);
    check("mid_rst_x1", o_scroll_x1, 0);
    check("mid_rst_x2", o_scroll_x2, 0);
    check("mid_rst_frame", o_frame, 0);
    check("mid_rst_ready", o_cfg_ready, 1);
    check("mid_rst_overrun", o_overrun, 0);
    check("mid_rst_en", o_layer_en, 7);
    @(negedge clk);
    i_reset = 1'b0;
    model_reset();
    run_frame(2, 1'b0, 0, 0);
    check_model("post_rst");

    for (int it = 0; it < 60; it++) begin
      int nw;
      int a;
      int d;
      nw = $urandom_range(0, 2);
      for (int w = 0; w < nw; w++) begin
        a = $urandom_range(0, 7);
        d = $urandom_range(0, 255);
        cfg_write(a, d);
      end
      a = $urandom_range(0, 7);
      d = $urandom_range(0, 255);
      run_frame($urandom_range(1, 5), ($urandom_range(0, 3) == 0), a, d);
      check_model("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
